// File: rtl/cam_capture_rgb444.sv
// OV7670 capture stage: pairs RGB565 bytes into RGB444 pixels and writes them to the frame buffer.
// Optional colour-bar generator enabled by defining CAM_CAPTURE_TESTPAT_EN.
module cam_capture_rgb444 #(
    parameter int AW           = 15,
    parameter int DW           = 12,
    parameter int CAM_SCREEN_X = 160,
    parameter int CAM_SCREEN_Y = 120
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          CAM_vsync,
    input  logic          CAM_href,
    input  logic [7:0]    CAM_px_data,
    output logic [AW-1:0] DP_RAM_addr_in,
    output logic [DW-1:0] DP_RAM_data_in,
    output logic          DP_RAM_regW,
    output logic          frame_done,
    output logic          overflow
);

    localparam logic [AW-1:0] PIX_LAST = AW'(CAM_SCREEN_X * CAM_SCREEN_Y);

    typedef enum logic [1:0] {IDLE, SYNC, CAPTURE} state_t;

    state_t        state, state_nx;
    logic          phase;
    logic [7:0]    byte1;
    logic [AW-1:0] pix_cnt;
    logic          start_cap, end_cap, emit, wr;
    logic [DW-1:0] pixel;

    always_comb begin
        state_nx  = state;
        start_cap = 1'b0;
        end_cap   = 1'b0;
        case (state)
            IDLE:    if (CAM_vsync) state_nx = SYNC;
            SYNC:    if (!CAM_vsync) begin
                         state_nx  = CAPTURE;
                         start_cap = 1'b1;
                     end
            CAPTURE: if (CAM_vsync) begin
                         state_nx = SYNC;
                         end_cap  = 1'b1;
                     end
            default: state_nx = IDLE;
        endcase
    end

    // vsync dominates href, so a byte seen during blanking never completes a pixel
    assign emit = (state == CAPTURE) && !CAM_vsync && CAM_href && phase;
    assign wr   = emit && (pix_cnt != PIX_LAST);

`ifdef CAM_CAPTURE_TESTPAT_EN
    localparam int CW = $clog2(CAM_SCREEN_X);

    logic [CW-1:0] col;
    logic [CW-1:0] bar;
    logic          unused_cam;

    assign unused_cam = ^{byte1, CAM_px_data};
    assign bar        = col / CW'(20);

    always_comb begin
        pixel = '0;
        case (bar[2:0])
            3'd0: pixel = DW'(12'hFFF);
            3'd1: pixel = DW'(12'hFF0);
            3'd2: pixel = DW'(12'h0FF);
            3'd3: pixel = DW'(12'h0F0);
            3'd4: pixel = DW'(12'hF0F);
            3'd5: pixel = DW'(12'hF00);
            3'd6: pixel = DW'(12'h00F);
            default: pixel = DW'(12'h000);
        endcase
        if (bar >= CW'(8)) pixel = '0;
    end

    // column tracks pix_cnt mod line width without a divider
    always_ff @(posedge clk) begin
        if (!rst || start_cap) col <= '0;
        else if (wr)           col <= (col == CW'(CAM_SCREEN_X - 1)) ? '0 : col + 1'b1;
    end
`else
    assign pixel = DW'({byte1[7:4], byte1[2:0], CAM_px_data[7], CAM_px_data[4:1]});
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            phase          <= 1'b0;
            byte1          <= '0;
            pix_cnt        <= '0;
            DP_RAM_addr_in <= '0;
            DP_RAM_data_in <= '0;
            DP_RAM_regW    <= 1'b0;
            frame_done     <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            state       <= state_nx;
            DP_RAM_regW <= 1'b0;
            frame_done  <= end_cap;
            if (start_cap) begin
                pix_cnt  <= '0;
                phase    <= 1'b0;
                overflow <= 1'b0;
            end else if (state == CAPTURE) begin
                if (!CAM_vsync && CAM_href && !phase) begin
                    byte1 <= CAM_px_data;
                    phase <= 1'b1;
                end else begin
                    phase <= 1'b0;
                end
                if (wr) begin
                    DP_RAM_addr_in <= pix_cnt;
                    DP_RAM_data_in <= pixel;
                    DP_RAM_regW    <= 1'b1;
                    pix_cnt        <= pix_cnt + 1'b1;
                end else if (emit) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_capture_rgb444.sv
// Scoreboard bench for cam_capture_rgb444: stimulus pushes expected writes, a monitor pops them.
module tb_cam_capture_rgb444;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vs = 1'b0;
    logic        href = 1'b0;
    logic [7:0]  px = 8'h00;
    logic [14:0] addr;
    logic [11:0] data;
    logic        regw, fd, ovf;

    cam_capture_rgb444 dut (
        .clk(clk), .rst(rst), .CAM_vsync(vs), .CAM_href(href), .CAM_px_data(px),
        .DP_RAM_addr_in(addr), .DP_RAM_data_in(data), .DP_RAM_regW(regw),
        .frame_done(fd), .overflow(ovf)
    );

    always #5 clk = ~clk;

    typedef struct { logic [14:0] a; logic [11:0] d; } wr_t;
    wr_t sbq[$];
    int  checks = 0, failures = 0;
    int  wr_cnt = 0, fd_cnt = 0, n_exp = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (fd) fd_cnt++;
        if (regw) begin
            wr_cnt++;
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual addr=%0d data=0x%03h expected none", addr, data);
            end else begin
                e = sbq.pop_front();
                chk("wr_addr", int'(addr), int'(e.a));
                chk("wr_data", int'(data), int'(e.d));
            end
        end
    end

    function automatic logic [11:0] rgb(input logic [7:0] b1, input logic [7:0] b2);
        return {b1[7:4], b1[2:0], b2[7], b2[4:1]};
    endfunction

    function automatic logic [11:0] exp_pix(input logic [11:0] cam, input int n);
`ifdef CAM_CAPTURE_TESTPAT_EN
        case ((n % 160) / 20)
            0: return 12'hFFF;
            1: return 12'hFF0;
            2: return 12'h0FF;
            3: return 12'h0F0;
            4: return 12'hF0F;
            5: return 12'hF00;
            6: return 12'h00F;
            default: return 12'h000;
        endcase
`else
        if (n < 0) return 12'h000;
        return cam;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        href = 1'b1;
        px   = b;
        tick();
    endtask

    task automatic idle(input int n);
        href = 1'b0;
        repeat (n) tick();
    endtask

    task automatic pair(input logic [7:0] b1, input logic [7:0] b2, input logic [11:0] cam);
        wr_t e;
        send(b1);
        if (n_exp < 19200) begin
            e.a = 15'(n_exp);
            e.d = exp_pix(cam, n_exp);
            sbq.push_back(e);
        end
        send(b2);
        n_exp++;
    endtask

    initial begin
        wr_t e;
        // reset state
        tick(); tick();
        chk("rst_addr", int'(addr), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_regw", int'(regw), 0);
        chk("rst_frame_done", int'(fd), 0);
        chk("rst_overflow", int'(ovf), 0);
        rst = 1'b1;

        // mid-frame start: href toggling with vsync low must not write
        for (int i = 0; i < 12; i++) begin
            href = i[0];
            px   = 8'(i * 17);
            tick();
        end
        idle(1);
        chk("mid_frame_start_no_write", wr_cnt, 0);

        // frame 1: hand-computed pixels
        vs = 1'b1; tick(); tick();
        vs = 1'b0; tick();
        n_exp = 0; wr_cnt = 0; fd_cnt = 0;
        send(8'hF8);
        e.a = 15'd0; e.d = exp_pix(12'hF0F, 0); sbq.push_back(e);
        send(8'h1F);
        n_exp = 1;
        chk("first_write_latency", int'(regw), 1);
        chk("first_write_addr", int'(addr), 0);
        pair(8'h00, 8'h00, 12'h000);
        pair(8'hA5, 8'h5A, 12'hAAD);
        // pending byte with vsync rising (href also high): no pixel
        send(8'h12);
        vs = 1'b1; href = 1'b1; px = 8'h34; tick();
        chk("frame_done_pulse", int'(fd), 1);
        href = 1'b0; tick();
        chk("frame_done_one_cycle", int'(fd), 0);
        chk("frame1_writes", wr_cnt, 3);
        chk("frame1_sb_drained", sbq.size(), 0);
        chk("frame1_overflow", int'(ovf), 0);

        // frame 2: odd-byte line 0, 121 lines total -> overflow
        vs = 1'b0; tick();
        n_exp = 0; wr_cnt = 0; fd_cnt = 0;
        for (int ln = 0; ln < 121; ln++) begin
            for (int p = 0; p < 160; p++) begin
                logic [7:0] b1, b2;
                b1 = 8'(p * 13 + ln * 7);
                b2 = 8'(p * 29 + ln * 3 + 1);
                pair(b1, b2, rgb(b1, b2));
            end
            if (ln == 0) send(8'hC3);
            idle(2);
            if (ln == 0)   chk("odd_byte_line_writes", wr_cnt, 160);
            if (ln == 119) begin
                chk("full_frame_overflow_clear", int'(ovf), 0);
                chk("full_frame_writes", wr_cnt, 19200);
            end
        end
        chk("overflow_set", int'(ovf), 1);
        chk("overflow_write_cap", wr_cnt, 19200);
        vs = 1'b1; tick();
        chk("frame2_done_pulse", int'(fd), 1);
        tick();
        chk("overflow_held_in_sync", int'(ovf), 1);
        chk("frame2_done_count", fd_cnt, 1);
        chk("frame2_sb_drained", sbq.size(), 0);
        vs = 1'b0; tick();
        chk("overflow_cleared_at_start", int'(ovf), 0);

        // frame 3: reset at pixel 5000
        n_exp = 0; wr_cnt = 0;
        for (int p = 0; p < 5000; p++) pair(8'(p), ~8'(p), rgb(8'(p), ~8'(p)));
        rst = 1'b0; href = 1'b1; px = 8'h55; tick();
        chk("reset_mid_regw", int'(regw), 0);
        chk("reset_mid_addr", int'(addr), 0);
        rst = 1'b1;
        chk("frame3_writes", wr_cnt, 5000);
        for (int i = 0; i < 20; i++) send(8'(i + 3));
        idle(1);
        chk("after_reset_no_write", wr_cnt, 5000);
        vs = 1'b1; tick(); tick();
        vs = 1'b0; tick();
        n_exp = 0; fd_cnt = 0;
        pair(8'h12, 8'h34, 12'h14A);
        idle(2);
        vs = 1'b1; tick();
        chk("frame4_done_pulse", int'(fd), 1);
        tick();
        chk("final_writes", wr_cnt, 5001);
        chk("final_sb_drained", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cam_capture_rgb444.md
Name: cam_capture_rgb444

Overview:
- OV7670 pixel-capture stage; sits between the camera pins (CAM_pclk/href/vsync/px_data) and the dual-port frame buffer write port.
- Pairs RGB565 bytes into RGB444 pixels, generates linear QQVGA write addresses, and issues a one-cycle write strobe per pixel.
- Frame-synchronised by FSM: capture begins only at a clean frame start. Reports frame completion and overflow.

Parameters:
- AW, 15, write-address width.
- DW, 12, pixel width (RGB444).
- CAM_SCREEN_X, 160, pixels per line.
- CAM_SCREEN_Y, 120, lines per frame.

Ports:
- clk  in  1  camera pixel clock (CAM_pclk); all logic on rising edge.
- rst  in  1  synchronous reset, active-low.
- CAM_vsync  in  1  frame sync; high = vertical blanking.
- CAM_href  in  1  line valid; high = bytes on CAM_px_data valid.
- CAM_px_data  in  8  camera byte bus.
- DP_RAM_addr_in  out  AW  write address.
- DP_RAM_data_in  out  DW  pixel {R[3:0],G[3:0],B[3:0]}.
- DP_RAM_regW  out  1  write strobe, one cycle per pixel.
- frame_done  out  1  one-cycle pulse at end of captured frame.
- overflow  out  1  sticky per frame: more than CAM_SCREEN_X*CAM_SCREEN_Y pixels arrived.

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, phase=0, pix_cnt=0, byte1 reg=0. Outputs: DP_RAM_addr_in=0, DP_RAM_data_in=0, DP_RAM_regW=0, frame_done=0, overflow=0. Reset mid-frame aborts capture with no further writes; capture resumes only at the next full frame.
- FSM states:
  - IDLE: when vsync=1, go to SYNC.
  - SYNC: wait in blanking. When vsync=0, go to CAPTURE; pix_cnt<=0, phase<=0, overflow<=0.
  - CAPTURE: collect pixels. When vsync=1, go to SYNC and pulse frame_done=1 for one cycle.
- Byte pairing, CAPTURE only:
  - Edge with href=1, phase=0: byte1<=px_data, phase<=1.
  - Edge with href=1, phase=1: phase<=0 and emit a pixel. R=byte1[7:4], G={byte1[2:0],px_data[7]}, B=px_data[4:1].
  - href=0 forces phase<=0. An odd trailing byte at line end is discarded; no write.
- Write timing and latency:
  - On the emit edge: DP_RAM_data_in<=pixel, DP_RAM_addr_in<=pix_cnt, DP_RAM_regW<=1, pix_cnt<=pix_cnt+1.
  - Latency: write valid in the cycle after the second byte is sampled. regW is exactly one cycle wide.
  - addr/data hold their last values when regW=0.
- Boundaries:
  - Emit with pix_cnt = CAM_SCREEN_X*CAM_SCREEN_Y (19200): no write, regW stays 0, overflow<=1, pix_cnt saturates. Address never exceeds 19199.
  - The address CAM_SCREEN_X*CAM_SCREEN_Y is reserved for the read side's black pixel and is never written.
  - vsync rising while phase=1: pending byte1 is dropped.
  - frame_done fires even if the frame is short. pix_cnt is not cleared until the next SYNC→CAPTURE transition.
  - href and vsync both high: vsync wins and no pixel is emitted.
- No handshake back-pressure: the RAM accepts every regW.

Optional Feature:
- Macro: CAM_CAPTURE_TESTPAT_EN.
- Defined:
  - Pixel data is replaced by vertical colour bars computed from the column (pix_cnt mod CAM_SCREEN_X) / 20.
  - 8 bars: 0xFFF, 0xFF0, 0x0FF, 0x0F0, 0xF0F, 0xF00, 0x00F, 0x000.
  - Timing, addressing, FSM and overflow are unchanged; px_data is ignored.
- Undefined: pixel data comes from the camera bytes as above, and no bar logic is synthesised.

Test Plan:
- Reset then single pixel:
  - Stimulus: rst=0 for 2 cycles, vsync 1→0, href=1 with bytes 0xF8, 0x1F.
  - Response: after reset all outputs 0. One regW pulse with addr=0, data=0xF0F, the cycle after 0x1F is sampled.
- Full QQVGA frame:
  - Stimulus: 120 lines × 320 bytes, then vsync=1.
  - Response: 19200 regW pulses, addresses 0..19199 contiguous, frame_done pulses once, overflow=0.
- Mid-frame start:
  - Stimulus: release reset while vsync=0 and href is toggling.
  - Response: no writes until vsync has gone 1 then 0. The first write has addr=0.
- Odd byte and overflow:
  - Odd byte: a line with 321 bytes gives 160 writes, and the 321st byte produces no write.
  - Overflow: a frame with 121 lines gives writes that stop at addr 19199, overflow=1 until the next frame start, and overflow=0 after that.
- Reset mid-frame:
  - Stimulus: rst=0 at pixel 5000 for 1 cycle.
  - Response: regW=0 immediately after. The next write is addr=0, only after a full vsync 1→0.
- Test pattern (macro defined):
  - Stimulus: arbitrary px_data over one line.
  - Response: addresses 0..19 carry data 0xFFF and addresses 20..39 carry 0xFF0, with the 160th pixel (addr 159) equal to 0x000.
